// File: rtl/rs_branch.sv
// rs_branch: in-order branch reservation station with dual-bus operand wakeup.
module rs_branch #(
  parameter int DEPTH        = 4,
  parameter int TAG_W        = 4,
  parameter int OP_W         = 6,
  parameter int UNLOCKED_TAG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_en,
  input  logic [31:0]      alloc_pc,
  input  logic [31:0]      alloc_offset,
  input  logic [OP_W-1:0]  alloc_op,
  input  logic [TAG_W-1:0] alloc_tagx,
  input  logic [TAG_W-1:0] alloc_tagy,
  input  logic [31:0]      alloc_datax,
  input  logic [31:0]      alloc_datay,
  output logic             full,
  input  logic             cdb0_en,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_data,
  input  logic             cdb1_en,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_data,
  output logic [31:0]      pc_out,
  output logic [31:0]      offset_out,
  output logic             branch_busy_out,
  output logic [OP_W-1:0]  branch_op_out,
  output logic [TAG_W-1:0] branch_tagx_out,
  output logic [TAG_W-1:0] branch_tagy_out,
  output logic [31:0]      branch_datax_out,
  output logic [31:0]      branch_datay_out
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] UT = TAG_W'(UNLOCKED_TAG);

  logic [31:0]      pc_q [DEPTH], pc_d [DEPTH];
  logic [31:0]      off_q[DEPTH], off_d[DEPTH];
  logic [OP_W-1:0]  op_q [DEPTH], op_d [DEPTH];
  logic [TAG_W-1:0] tx_q [DEPTH], tx_d [DEPTH];
  logic [TAG_W-1:0] ty_q [DEPTH], ty_d [DEPTH];
  logic [31:0]      dx_q [DEPTH], dx_d [DEPTH];
  logic [31:0]      dy_q [DEPTH], dy_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             empty, pop, push;

  // Bus 0 is checked first so it wins when both buses carry the same tag.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] t, input logic [31:0] d,
    input logic e0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
    input logic e1, input logic [TAG_W-1:0] t1, input logic [31:0] d1);
    return (t == UT) ? {t, d} : (e0 && t0 == t) ? {UT, d0} : (e1 && t1 == t) ? {UT, d1} : {t, d};
  endfunction

  always_comb begin
    empty  = cnt_q == '0;
    full   = cnt_q == (PW+1)'(DEPTH);
    pop    = !empty && tx_q[head_q] == UT && ty_q[head_q] == UT;
    push   = alloc_en && !full;
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      pc_d[i]  = pc_q[i];
      off_d[i] = off_q[i];
      op_d[i]  = op_q[i];
      {tx_d[i], dx_d[i]} = {tx_q[i], dx_q[i]};
      {ty_d[i], dy_d[i]} = {ty_q[i], dy_q[i]};
      if ((PW+1)'(PW'(PW'(i) - head_q)) < cnt_q) begin
        {tx_d[i], dx_d[i]} = snoop(tx_q[i], dx_q[i], cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
        {ty_d[i], dy_d[i]} = snoop(ty_q[i], dy_q[i], cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
      end
      if (push && tail_q == PW'(i)) begin
        pc_d[i]  = alloc_pc;
        off_d[i] = alloc_offset;
        op_d[i]  = alloc_op;
        {tx_d[i], dx_d[i]} = snoop(alloc_tagx, alloc_datax, cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
        {ty_d[i], dy_d[i]} = snoop(alloc_tagy, alloc_datay, cdb0_en, cdb0_tag, cdb0_data, cdb1_en, cdb1_tag, cdb1_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        off_q[i] <= '0;
        op_q[i]  <= '0;
        tx_q[i]  <= UT;
        ty_q[i]  <= UT;
        dx_q[i]  <= '0;
        dy_q[i]  <= '0;
      end
    end else if (rdy) begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      off_q  <= off_d;
      op_q   <= op_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
    end
  end

  assign branch_busy_out  = !empty;
  assign pc_out           = empty ? '0 : pc_q[head_q];
  assign offset_out       = empty ? '0 : off_q[head_q];
  assign branch_op_out    = empty ? '0 : op_q[head_q];
  assign branch_tagx_out  = empty ? UT : tx_q[head_q];
  assign branch_tagy_out  = empty ? UT : ty_q[head_q];
  assign branch_datax_out = empty ? '0 : dx_q[head_q];
  assign branch_datay_out = empty ? '0 : dy_q[head_q];
endmodule

// File: tb/tb_rs_branch.sv
// tb_rs_branch: random and directed stimulus against a queue-based model of the station.
module tb_rs_branch;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc, off;
    logic [5:0]  op;
    logic [3:0]  tx, ty;
    logic [31:0] dx, dy;
  } ent_t;

  logic        clk = 0, rst = 1, rdy = 1, alloc_en = 0, cdb0_en = 0, cdb1_en = 0;
  logic [31:0] alloc_pc = 0, alloc_offset = 0, alloc_datax = 0, alloc_datay = 0, cdb0_data = 0, cdb1_data = 0;
  logic [5:0]  alloc_op = 0;
  logic [3:0]  alloc_tagx = 0, alloc_tagy = 0, cdb0_tag = 0, cdb1_tag = 0;
  logic        full, branch_busy_out;
  logic [31:0] pc_out, offset_out, branch_datax_out, branch_datay_out;
  logic [5:0]  branch_op_out;
  logic [3:0]  branch_tagx_out, branch_tagy_out;

  ent_t q[$];
  int n_chk = 0, n_fail = 0;

  rs_branch #(.DEPTH(DEPTH), .TAG_W(4), .OP_W(6), .UNLOCKED_TAG(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .alloc_en(alloc_en), .alloc_pc(alloc_pc),
    .alloc_offset(alloc_offset), .alloc_op(alloc_op), .alloc_tagx(alloc_tagx),
    .alloc_tagy(alloc_tagy), .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
    .full(full), .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .pc_out(pc_out), .offset_out(offset_out), .branch_busy_out(branch_busy_out),
    .branch_op_out(branch_op_out), .branch_tagx_out(branch_tagx_out),
    .branch_tagy_out(branch_tagy_out), .branch_datax_out(branch_datax_out),
    .branch_datay_out(branch_datay_out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (r.tx != 0) begin
      if (cdb0_en && cdb0_tag == r.tx) begin r.tx = 0; r.dx = cdb0_data; end
      else if (cdb1_en && cdb1_tag == r.tx) begin r.tx = 0; r.dx = cdb1_data; end
    end
    if (r.ty != 0) begin
      if (cdb0_en && cdb0_tag == r.ty) begin r.ty = 0; r.dy = cdb0_data; end
      else if (cdb1_en && cdb1_tag == r.ty) begin r.ty = 0; r.dy = cdb1_data; end
    end
    return r;
  endfunction

  task automatic model_edge();
    ent_t e;
    bit pop, acc;
    if (rst) begin q.delete(); return; end
    if (!rdy) return;
    pop = q.size() > 0 && q[0].tx == 0 && q[0].ty == 0;
    acc = alloc_en && q.size() < DEPTH;
    foreach (q[i]) q[i] = wake(q[i]);
    e = '{alloc_pc, alloc_offset, alloc_op, alloc_tagx, alloc_tagy, alloc_datax, alloc_datay};
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(wake(e));
  endtask

  task automatic check_outs();
    ent_t h = '{0, 0, 0, 0, 0, 0, 0};
    if (q.size() > 0) h = q[0];
    check("busy", 32'(branch_busy_out), 32'(q.size() > 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("pc", pc_out, h.pc);
    check("offset", offset_out, h.off);
    check("op", 32'(branch_op_out), 32'(h.op));
    check("tagx", 32'(branch_tagx_out), 32'(h.tx));
    check("tagy", 32'(branch_tagy_out), 32'(h.ty));
    check("datax", branch_datax_out, h.dx);
    check("datay", branch_datay_out, h.dy);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic alloc(input logic [31:0] pc, off, input logic [5:0] op,
                       input logic [3:0] tx, ty, input logic [31:0] dx, dy);
    alloc_en = 1; alloc_pc = pc; alloc_offset = off; alloc_op = op;
    alloc_tagx = tx; alloc_tagy = ty; alloc_datax = dx; alloc_datay = dy;
  endtask

  initial begin
    @(negedge clk);
    cyc();
    rst = 0;
    cyc();
    check("idle_busy", 32'(branch_busy_out), 0);
    check("idle_tagx", 32'(branch_tagx_out), 0);
    // ready branch: presented after edge 1, popped at edge 2
    alloc(32'h100, 32'h20, 6'd0, 0, 0, 5, 5);
    cyc();
    check("beq_pc", pc_out, 32'h100);
    check("beq_off", offset_out, 32'h20);
    alloc_en = 0;
    cyc();
    check("beq_popped", 32'(branch_busy_out), 0);
    // rs1 waits on tag 3, woken by bus 1
    alloc(32'h200, 32'h40, 6'd1, 3, 0, 0, 9);
    cyc();
    alloc_en = 0;
    repeat (5) cyc();
    check("held_busy", 32'(branch_busy_out), 1);
    cdb1_en = 1; cdb1_tag = 3; cdb1_data = 7;
    cyc();
    cdb1_en = 0;
    check("woke_datax", branch_datax_out, 7);
    check("woke_tagx", 32'(branch_tagx_out), 0);
    cyc();
    check("woke_popped", 32'(branch_busy_out), 0);
    // alloc-time wakeup
    alloc(32'h300, 32'h8, 6'd2, 0, 2, 1, 0);
    cdb0_en = 1; cdb0_tag = 2; cdb0_data = 32'hAB;
    cyc();
    alloc_en = 0; cdb0_en = 0;
    check("alloc_wake_datay", branch_datay_out, 32'hAB);
    check("alloc_wake_tagy", 32'(branch_tagy_out), 0);
    cyc();
    // fill behind a blocked head, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      alloc(32'h400 + 32'(i), 32'(i), 6'(i + 3), i == 0 ? 4'd5 : 4'd0, 0, 32'(i), 32'(i));
      cyc();
    end
    check("fill_full", 32'(full), 1);
    alloc(32'h999, 0, 6'd9, 0, 0, 0, 0);
    cyc();
    alloc_en = 0;
    cdb0_en = 1; cdb0_tag = 5; cdb0_data = 32'h55;
    cyc();
    cdb0_en = 0;
    check("full_still", 32'(full), 1);
    alloc(32'h998, 0, 6'd9, 0, 0, 0, 0);
    cyc();
    check("drop_on_pop", pc_out, 32'h401);
    alloc(32'h500, 0, 6'd4, 0, 0, 0, 0);
    cyc();
    alloc_en = 0;
    repeat (6) cyc();
    // reset while holding entries
    alloc(32'h600, 0, 6'd5, 6, 0, 0, 0);
    cyc();
    cyc();
    rst = 1; alloc_en = 0;
    cyc();
    rst = 0;
    check("rst_busy", 32'(branch_busy_out), 0);
    // streaming with a rdy stall
    for (int i = 0; i < 12; i++) begin
      alloc(32'h700 + 32'(i), 32'(i), 6'(i), 0, 0, 32'(i), 32'(~i));
      rdy = !(i >= 5 && i < 8);
      cyc();
    end
    rdy = 1; alloc_en = 0;
    repeat (4) cyc();
    // random
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      rdy = $urandom_range(0, 9) != 0;
      alloc($urandom, $urandom, 6'($urandom),
            $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 7)) : 4'd0,
            $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 7)) : 4'd0,
            $urandom, $urandom);
      alloc_en = $urandom_range(0, 1);
      cdb0_en = $urandom_range(0, 1); cdb0_tag = 4'($urandom_range(0, 7)); cdb0_data = $urandom;
      cdb1_en = $urandom_range(0, 1); cdb1_tag = 4'($urandom_range(0, 7)); cdb1_data = $urandom;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
